// File: rtl/booth_pkg.sv
// ============================================================================
// Module   : booth_pkg
// Purpose  : Shared state encoding and Booth recode constants for booth_mult_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Booth recode of {Q[0], q_m1}
  localparam logic [1:0] BR_ADD = 2'b01;
  localparam logic [1:0] BR_SUB = 2'b10;

endpackage

`default_nettype wire

// File: rtl/booth_addsub.sv
// ============================================================================
// Module   : booth_addsub
// Purpose  : Combinational Booth step: A+M, A-M or A selected by {Q[0], q_m1}.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_addsub
  import booth_pkg::*;
#(
  parameter int E = 9
) (
  input  logic [E-1:0] a,
  input  logic [E-1:0] m,
  input  logic [1:0]   rec,
  output logic [E-1:0] sum
);

  always_comb begin
    sum = a;
    case (rec)
      BR_ADD:  sum = a + m;
      BR_SUB:  sum = a - m;
      default: sum = a;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/booth_mult_seq.sv
// ============================================================================
// Module   : booth_mult_seq
// Purpose  : Sequential radix-2 Booth multiplier, signed/unsigned, start/done.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int E = WIDTH + 1;

  state_t             r_state;
  logic [E-1:0]       r_a;
  logic [E-1:0]       r_q;
  logic               r_qm1;
  logic [E-1:0]       r_m;
  logic [CW-1:0]      r_count;
  logic               r_done;
  logic [2*WIDTH-1:0] r_product;

  logic [E-1:0]       w_sum;
  logic [E-1:0]       w_a_sh;
  logic [E-1:0]       w_q_sh;
  logic [2*E-1:0]     w_aq;
  logic [E-1:0]       w_ext_a;
  logic [E-1:0]       w_ext_b;
  logic               w_accept;

  // One extra bit lets unsigned operands use the same signed Booth datapath
  assign w_ext_a  = {is_signed & op_a[WIDTH-1], op_a};
  assign w_ext_b  = {is_signed & op_b[WIDTH-1], op_b};
  assign w_accept = start & ready;

  booth_addsub #(.E(E)) u_addsub (
    .a   (r_a),
    .m   (r_m),
    .rec ({r_q[0], r_qm1}),
    .sum (w_sum)
  );

  assign w_a_sh = {w_sum[E-1], w_sum[E-1:1]};
  assign w_q_sh = {w_sum[0], r_q[E-1:1]};
  assign w_aq   = {w_a_sh, w_q_sh};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_a       <= '0;
      r_q       <= '0;
      r_qm1     <= 1'b0;
      r_m       <= '0;
      r_count   <= '0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_m     <= w_ext_a;
            r_q     <= w_ext_b;
            r_a     <= '0;
            r_qm1   <= 1'b0;
            r_count <= CW'(E);
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_a     <= w_a_sh;
          r_q     <= w_q_sh;
          r_qm1   <= r_q[0];
          r_count <= r_count - 1'b1;
          if (r_count == CW'(1)) begin
            r_product <= w_aq[2*WIDTH-1:0];
            r_done    <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ready   = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign busy    = (r_state == ST_RUN);
  assign done    = r_done;
  assign product = r_product;

endmodule

`default_nettype wire

// File: tb/tb_booth_mult_seq.sv
// ============================================================================
// Module   : tb_booth_mult_seq
// Purpose  : Directed vector bench for booth_mult_seq at WIDTH=8.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_booth_mult_seq;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           is_signed;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int n_cmp  = 0;
  int n_fail = 0;

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           sgn;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Edges counted from the start edge until done is seen high
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    @(negedge clk);
    is_signed = v.sgn; op_a = v.a; op_b = v.b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    check($sformatf("latency[%0d]", idx), n, 9);
    check($sformatf("product[%0d]", idx), product, v.exp);
  endtask

  initial begin
    int n;
    int seen;
    vecs[0]  = '{1'b1, 8'hF9, 8'h05, 16'hFFDD};
    vecs[1]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
    vecs[2]  = '{1'b1, 8'h80, 8'h7F, 16'hC080};
    vecs[3]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vecs[4]  = '{1'b0, 8'd200, 8'd3, 16'h0258};
    vecs[5]  = '{1'b1, 8'h00, 8'h55, 16'h0000};
    vecs[6]  = '{1'b0, 8'h55, 8'hAA, 16'h3872};
    vecs[7]  = '{1'b1, 8'h55, 8'hAA, 16'hE372};
    vecs[8]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
    vecs[9]  = '{1'b0, 8'h80, 8'h80, 16'h4000};
    vecs[10] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};
    vecs[11] = '{1'b0, 8'hFF, 8'h01, 16'h00FF};
    vecs[12] = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};

    rst = 1'b1; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_product", product, 0);
    @(negedge clk); rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // start held through RUN with new operands, then re-accepted in DONE
    @(negedge clk);
    is_signed = 1'b1; op_a = 8'hF9; op_b = 8'h05; start = 1'b1;
    @(posedge clk); #1;
    is_signed = 1'b0; op_a = 8'd3; op_b = 8'd4;
    check("busy_after_start", busy, 1);
    wait_done(n);
    check("hold_latency", n, 9);
    check("hold_product", product, 16'hFFDD);
    check("done_ready", ready, 1);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy", busy, 1);
    check("b2b_done_low", done, 0);
    wait_done(n);
    check("b2b_latency", n, 9);
    check("b2b_product", product, 16'h000C);
    @(posedge clk); #1;
    check("done_pulse_width", done, 0);
    check("back_to_idle", ready, 1);

    // Abort mid-operation
    @(negedge clk);
    is_signed = 1'b0; op_a = 8'h55; op_b = 8'hAA; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("abort_ready", ready, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_product", product, 0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    check("abort_no_done", seen, 0);

    run_vec(vecs[0], 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Parametrised sequential radix-2 Booth multiplier. Datapath and controller are in one block.
- Generalises the fixed 5-bit, split datapath/controlpath Booth design to WIDTH-bit operands.
- Adds a per-operation signed/unsigned mode, single-cycle capture of both operands, and a start/busy/done handshake.
- Sits beside the ALU/shift-register blocks as a reusable multiply unit for higher-level controllers.

Parameters:
- WIDTH, 8, operand width in bits. Legal range is WIDTH >= 2.
- CW, $clog2(WIDTH+2), iteration counter width. Derived; do not override.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a multiply. Sampled only when ready=1.
- is_signed  input  1  1 = two's-complement operands; 0 = unsigned. Captured with start.
- op_a  input  WIDTH  multiplicand. Captured with start.
- op_b  input  WIDTH  multiplier. Captured with start.
- ready  output  1  high in IDLE and DONE.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse: product is valid.
- product  output  2*WIDTH  registered result. Held until the next completion or reset.

Behaviour:
- Reset is synchronous, active-high. On reset: state=IDLE, ready=1, busy=0, done=0, product=0, and all internal registers (A, Q, q_m1, M, count) are cleared.
- Reset has priority over everything, including mid-operation. An aborted operation produces no done and leaves product=0.
- Internal width is E=WIDTH+1.
  - M and Q hold the operands extended to E bits: sign-extended when is_signed=1, zero-extended when is_signed=0.
  - A is E bits; q_m1 is 1 bit.
- Start, edge 0: on the edge where start=1 and ready=1:
  - M <= ext(op_a), Q <= ext(op_b), A <= 0, q_m1 <= 0, count <= E.
  - Next state is RUN.
- Iteration: each RUN cycle performs exactly one Booth step.
  - {Q[0],q_m1} = 10: A_next = A - M.
  - {Q[0],q_m1} = 01: A_next = A + M.
  - 00 or 11: A_next = A.
  - Then arithmetic right shift of {A_next, Q, q_m1}: A MSB is replicated, A[0] shifts into Q MSB, Q[0] shifts into q_m1.
  - count decrements by 1.
  - Add/sub is modulo 2^E; overflow is discarded.
- Completion:
  - The iteration with count==1 is the last. On that same edge: product <= lower 2*WIDTH bits of the shifted {A,Q}, state -> DONE, done=1 for the following cycle.
  - Latency: done is high in the cycle after edge E (WIDTH+1) counting from the start edge. For WIDTH=8 that is edge 9.
  - Latency is fixed and independent of operand values.
- DONE lasts one cycle, then returns to IDLE. A start sampled in DONE is accepted exactly as in IDLE, giving back-to-back operations with no bubble beyond DONE.
- start is ignored while busy=1. Operand and is_signed changes during RUN have no effect.
- FSM:
  - IDLE --start--> RUN.
  - RUN --count==1--> DONE.
  - RUN --else--> RUN.
  - DONE --start--> RUN.
  - DONE --else--> IDLE.
  - Encoding is 2-bit; the unused code returns to IDLE.
- Outputs: ready and busy decode combinationally from state. done and product are registered.
- Correctness: the exact product always fits in 2*WIDTH bits for both modes, so truncating the 2E-bit result is lossless.
  - Signed extremes include (-2^(W-1))^2.
  - Unsigned extremes include (2^W-1)^2.

Decomposition:
- Shared package booth_pkg holds the state encoding constants (ST_IDLE, ST_RUN, ST_DONE) and the Booth recode constants (BR_ADD=2'b01, BR_SUB=2'b10).
- One natural sub-module: booth_addsub. It is combinational, E-bit wide, and returns A±M or A according to {Q[0],q_m1}.
- The FSM, counter and shift registers stay in the top module.

Test Plan:
- WIDTH=8, is_signed=1, op_a=-7 (0xF9), op_b=5 -> done exactly 9 edges after start; product=0xFFDD (-35).
- WIDTH=8, is_signed=1, op_a=op_b=0x80 (-128) -> product=0x4000 (16384). Also op_a=0x80, op_b=0x7F -> product=0xC080 (-16256).
- WIDTH=8, is_signed=0, op_a=op_b=0xFF -> product=0xFE01 (65025). Also op_a=200, op_b=3 -> product=0x0258.
- Start held high during RUN with different operands -> ignored. A second start in the DONE cycle -> accepted; second done after 9 more edges; no extra idle cycle.
- Assert rst at iteration 4 -> next cycle: state IDLE, product=0, done=0, ready=1; no done pulse follows.
- WIDTH=4 and WIDTH=16 builds: randomised 1000 signed and unsigned vectors against a reference product, including 0 operands and alternating-bit multipliers (0x55, 0xAA) -> all match; latency is WIDTH+1 edges every time.
